stack_mem_ctrl: RTL

STACK_MEM_CTRL -- requirements
Module: stack_mem_ctrl

---
 rtl/stack_pkg.sv | 30 +++
 rtl/stack_ptr_counter.sv | 35 +++
 rtl/stack_mem_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack memory controller: widths, command and
// error encodings, and the controller FSM state set.
package stack_pkg;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 14;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      OP_PEEK = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_POP2 = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ERR_OK  = 2'b00,
      ERR_OVF = 2'b01,
      ERR_UDF = 2'b10
   } err_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_WAIT,
      S_RESP
   } state_e;

endpackage

// File: rtl/stack_ptr_counter.sv
// Element counter for the stack: +1 on a write, -1/-2 on pops, with the
// occupancy flags the controller uses to classify overflow/underflow.
module stack_ptr_counter
   import stack_pkg::*;
#(
   parameter int DEPTH = 16383
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc1,
   input  logic             dec1,
   input  logic             dec2,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             lt2
);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc1)
         count <= count + CNT_W'(1);
      else if (dec1)
         count <= count - CNT_W'(1);
      else if (dec2)
         count <= count - CNT_W'(2);
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign lt2   = (count < CNT_W'(2));

endmodule

// File: rtl/stack_mem_ctrl.sv
// Stack controller over an external synchronous dual-read memory: one command
// at a time, with a top/second-of-stack response and a ready/valid handshake.
module stack_mem_ctrl
   import stack_pkg::*;
#(
   parameter logic [ADDR_W-1:0] STACK_BASE = 16'h0000,
   parameter int                DEPTH      = 16383
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_top,
   output logic [DATA_W-1:0] rsp_second,
   output logic [1:0]        rsp_err,
   output logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_douta,
   input  logic [DATA_W-1:0] mem_doutb
);

   state_e            state, next_state;
   op_e               op;
   err_e              err_code;
   logic              accept, cmd_err;
   logic              full, empty, lt2;
   logic              inc1, dec1, dec2;
   logic [DATA_W-1:0] push_data;

   assign op     = op_e'(cmd_op);
   assign accept = cmd_valid && (state == S_IDLE);

   // NOTE: every signal written in a combinational block gets a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      err_code = ERR_OK;
      case (op)
         OP_PUSH: if (full)  err_code = ERR_OVF;
         OP_POP:  if (empty) err_code = ERR_UDF;
         OP_POP2: if (lt2)   err_code = ERR_UDF;
         default: ;
      endcase
   end

   assign cmd_err = (err_code != ERR_OK);
   // Pops shrink the count at accept so the following read sees the new top.
   assign dec1    = accept && !cmd_err && (op == OP_POP);
   assign dec2    = accept && !cmd_err && (op == OP_POP2);

   stack_ptr_counter #(
      .DEPTH(DEPTH)
   ) u_counter (
      .clk  (clk),
      .reset(reset),
      .inc1 (inc1),
      .dec1 (dec1),
      .dec2 (dec2),
      .count(count),
      .full (full),
      .empty(empty),
      .lt2  (lt2)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_err)
                  next_state = S_RESP;
               else if (op == OP_PUSH)
                  next_state = S_WRITE;
               else
                  next_state = S_READ;
            end
         end
         S_WRITE: next_state = S_READ;
         S_READ:  next_state = S_WAIT;
         S_WAIT:  next_state = S_RESP;
         S_RESP:  if (rsp_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      mem_din   = '0;
      inc1      = 1'b0;
      mem_addr  = STACK_BASE + ADDR_W'(count);
      case (state)
         S_IDLE: cmd_ready = 1'b1;
         S_WRITE: begin
            mem_we   = 1'b1;
            mem_din  = push_data;
            mem_addr = STACK_BASE + ADDR_W'(count) + ADDR_W'(1);
            inc1     = 1'b1;
         end
         S_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Error responses leave rsp_top/rsp_second untouched; only WAIT reloads them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_data  <= '0;
         rsp_top    <= '0;
         rsp_second <= '0;
         rsp_err    <= ERR_OK;
      end else begin
         if (accept) begin
            push_data <= cmd_data;
            rsp_err   <= err_code;
         end
         if (state == S_WAIT) begin
            rsp_top    <= (count == '0)          ? '0 : mem_douta;
            rsp_second <= (count < CNT_W'(2))    ? '0 : mem_doutb;
         end
      end
   end

endmodule
